// File: rtl/proc_pkg.sv
// Shared processor types and constants for the destination-register tracker.
package proc_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  memread;
    logic [REG_ADDR_W-1:0] rd;
  } dest_slot_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  // A slot commits a register write only for a live instruction targeting a real register.
  function automatic logic slot_writes(input dest_slot_t s, input logic [REG_ADDR_W-1:0] zero);
    return s.valid && s.regwrite && (s.rd != zero);
  endfunction

endpackage

// File: rtl/dest_reg_tracker_dec5_32.sv
// 5-to-32 one-hot decoder with enable; drives the register-file write enables.
module dec5_32 (
  input  logic        en,
  input  logic [4:0]  addr,
  output logic [31:0] onehot_c
);

  always_comb begin
    onehot_c = '0;
    if (en) onehot_c[addr] = 1'b1;
  end

endmodule

// File: rtl/dest_reg_tracker.sv
// Tracks destination registers through EX/MEM/WB, drives WB write enables and ID hazard/forwarding.
// Optional forwarding is enabled by defining DEST_TRACK_FWD_EN.
module dest_reg_tracker #(
  parameter int unsigned             ADDR_W   = proc_pkg::REG_ADDR_W,
  parameter int unsigned             NREGS    = proc_pkg::NUM_REGS,
  parameter logic [ADDR_W-1:0]       ZERO_REG = proc_pkg::ZERO_REG
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic [ADDR_W-1:0] id_rn,
  input  logic [ADDR_W-1:0] id_rm,
  input  logic              stall,
  input  logic              flush,
  output logic [NREGS-1:0]  wb_we,
  output logic [ADDR_W-1:0] wb_rd,
  output logic              hazard,
  output logic [1:0]        fwd_rn,
  output logic [1:0]        fwd_rm
);

  import proc_pkg::*;

  dest_slot_t ex_q, ex_d;
  dest_slot_t mem_q, mem_d;
  dest_slot_t wb_q, wb_d;

  logic ex_wr, mem_wr, wb_wr;
  logic rn_ex, rm_ex, rn_mem, rm_mem;
  logic unused_memread;

  // Source-versus-destination matches; the zero register is never a dependency.
  always_comb begin
    ex_wr  = slot_writes(ex_q, ZERO_REG);
    mem_wr = slot_writes(mem_q, ZERO_REG);
    wb_wr  = slot_writes(wb_q, ZERO_REG);
    rn_ex  = ex_wr  && (id_rn != ZERO_REG) && (ex_q.rd  == id_rn);
    rm_ex  = ex_wr  && (id_rm != ZERO_REG) && (ex_q.rd  == id_rm);
    rn_mem = mem_wr && (id_rn != ZERO_REG) && (mem_q.rd == id_rn);
    rm_mem = mem_wr && (id_rm != ZERO_REG) && (mem_q.rd == id_rm);
  end

  // WB matches need nothing: the register file writes through to the same-cycle read.
  always_comb begin
    hazard = 1'b0;
    fwd_rn = FWD_RF;
    fwd_rm = FWD_RF;
`ifdef DEST_TRACK_FWD_EN
    if (id_valid) begin
      hazard = ex_q.memread && (rn_ex || rm_ex);
      if (rn_ex)       fwd_rn = FWD_EXMEM;
      else if (rn_mem) fwd_rn = FWD_MEMWB;
      if (rm_ex)       fwd_rm = FWD_EXMEM;
      else if (rm_mem) fwd_rm = FWD_MEMWB;
    end
`else
    if (id_valid) begin
      hazard = rn_ex || rm_ex || rn_mem || rm_mem;
    end
`endif
  end

  // Slot advance; flush kills what would enter EX and MEM but lets the committed MEM entry retire.
  always_comb begin
    ex_d  = '0;
    mem_d = '0;
    wb_d  = mem_q;
    if (id_valid && !stall && !hazard && !flush) begin
      ex_d.valid    = 1'b1;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_d.rd       = id_rd;
    end
    if (!flush) mem_d = ex_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign wb_rd = wb_q.valid ? wb_q.rd : '0;

  dec5_32 u_wb_dec (
    .en       (wb_wr),
    .addr     (wb_q.rd),
    .onehot_c (wb_we)
  );

  // memread only matters for load-use in EX; later copies ride along to keep slots uniform.
  assign unused_memread = ^{ex_q.memread, mem_q.memread, wb_q.memread};

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Directed scoreboard bench for dest_reg_tracker; expectations track DEST_TRACK_FWD_EN.
module tb_dest_reg_tracker;

  localparam logic [1:0] RF = 2'b00;
  localparam logic [1:0] EX = 2'b01;
  localparam logic [1:0] MW = 2'b10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        id_valid = 1'b0;
  logic        id_regwrite = 1'b0;
  logic        id_memread = 1'b0;
  logic [4:0]  id_rd = 5'd0;
  logic [4:0]  id_rn = 5'd31;
  logic [4:0]  id_rm = 5'd31;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] wb_we;
  logic [4:0]  wb_rd;
  logic        hazard;
  logic [1:0]  fwd_rn;
  logic [1:0]  fwd_rm;

  typedef struct {
    logic [31:0] we;
    logic [4:0]  wb_rd;
    logic        haz;
    logic [1:0]  frn;
    logic [1:0]  frm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  dest_reg_tracker dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .id_valid    (id_valid),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_rd       (id_rd),
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .stall       (stall),
    .flush       (flush),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .hazard      (hazard),
    .fwd_rn      (fwd_rn),
    .fwd_rm      (fwd_rm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  // Drive one cycle of ID inputs and queue the outputs expected at that cycle's midpoint.
  task automatic step(input logic rstn, input logic v, input logic rw, input logic mr,
                      input int rd, input int rn, input int rm, input logic st, input logic fl,
                      input int we_idx, input int wbrd,
                      input logic haz_nf, input logic haz_f, input logic [1:0] frn_f,
                      input logic [1:0] frm_f);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n     = rstn;
    id_valid    = v;
    id_regwrite = rw;
    id_memread  = mr;
    id_rd       = 5'(rd);
    id_rn       = 5'(rn);
    id_rm       = 5'(rm);
    stall       = st;
    flush       = fl;
    e.we    = (we_idx < 0) ? 32'h0 : (32'h1 << we_idx);
    e.wb_rd = 5'(wbrd);
`ifdef DEST_TRACK_FWD_EN
    e.haz = haz_f;
    e.frn = frn_f;
    e.frm = frm_f;
`else
    e.haz = haz_nf;
    e.frn = RF;
    e.frm = RF;
`endif
    exp_q.push_back(e);
  endtask

  task automatic idle(input int we_idx, input int wbrd);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 31, 31, 1'b0, 1'b0, we_idx, wbrd, 1'b0, 1'b0, RF, RF);
  endtask

  task automatic wr(input int rd, input logic mr);
    step(1'b1, 1'b1, 1'b1, mr, rd, 31, 31, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, RF, RF);
  endtask

  // Monitor: pops one expectation per cycle and compares at the falling edge.
  initial begin
    exp_t e;
    int   n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wb_we",  n, wb_we, e.we);
        chk("wb_rd",  n, 32'(wb_rd), 32'(e.wb_rd));
        chk("hazard", n, 32'(hazard), 32'(e.haz));
        chk("fwd_rn", n, 32'(fwd_rn), 32'(e.frn));
        chk("fwd_rm", n, 32'(fwd_rm), 32'(e.frm));
        n++;
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1 reset_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 31, 31, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, RF, RF);
    // basic write-back of r5, visible three cycles later only
    wr(5, 1'b0);
    idle(-1, 0); idle(-1, 0); idle(5, 5); idle(-1, 0);
    // zero register: never written, never a dependency
    wr(31, 1'b0);
    idle(-1, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 31, 31, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, RF, RF);
    idle(-1, 31); idle(-1, 0); idle(-1, 0); idle(-1, 0);
    // EX then MEM dependency on r3
    wr(3, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 3, 31, 1'b0, 1'b0, -1, 0, 1'b1, 1'b0, EX, RF);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 31, 3, 1'b0, 1'b0, -1, 0, 1'b1, 1'b0, RF, MW);
    idle(3, 3); idle(-1, 0); idle(-1, 0); idle(-1, 0);
    // load-use on r7, retried the following cycle
    wr(7, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8, 7, 31, 1'b0, 1'b0, -1, 0, 1'b1, 1'b1, EX, RF);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8, 7, 31, 1'b0, 1'b0, -1, 0, 1'b1, 1'b0, MW, RF);
    idle(7, 7); idle(-1, 0);
`ifdef DEST_TRACK_FWD_EN
    idle(8, 8);
`else
    idle(-1, 0);
`endif
    idle(-1, 0);
    // external stall bubbles the first r9, the re-issue commits
    step(1'b1, 1'b1, 1'b1, 1'b0, 9, 31, 31, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0, RF, RF);
    wr(9, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 9, 9, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, RF, RF);
    idle(-1, 0); idle(9, 9);
    // flush kills r2 (EX) and r4 (ID); r1 in MEM still retires
    wr(1, 1'b0);
    wr(2, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4, 2, 1, 1'b0, 1'b1, -1, 0, 1'b1, 1'b0, EX, MW);
    idle(1, 1); idle(-1, 0); idle(-1, 0); idle(-1, 0);
    // asynchronous reset with three entries in flight
    wr(11, 1'b0); wr(12, 1'b0); wr(13, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 13, 12, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, RF, RF);
    idle(-1, 0); idle(-1, 0); idle(-1, 0); idle(-1, 0);
    // address boundaries r0 and r30
    wr(0, 1'b0); wr(30, 1'b0);
    idle(-1, 0); idle(0, 0); idle(30, 30);
    // EX-over-MEM priority, then WB-only match needs nothing
    wr(20, 1'b0); wr(20, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 20, 20, 1'b0, 1'b0, -1, 0, 1'b1, 1'b0, EX, EX);
    idle(20, 20);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 20, 20, 1'b0, 1'b0, 20, 20, 1'b0, 1'b0, RF, RF);
    idle(-1, 0); idle(-1, 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
